// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit: E-stage op codes, latency
// defaults and the R-type func codes the decoder maps onto md_op/start/sel_hi.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  // R-type func field values for the HI/LO instruction group.
  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1a;
  localparam logic [5:0] FUNC_DIVU  = 6'h1b;

  // True for the four ops that start a multi-cycle operation.
  function automatic logic is_arith_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Purely combinational 64-bit product and quotient/remainder for md_unit.
// Signed divide works on magnitudes so 0x80000000 / -1 wraps naturally.
module md_arith
  import md_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  md_op_e      op,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        sgn_div;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] quo;
  logic [31:0] rem;

  // Select operand extension, form product and magnitude divide, then pick the result.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hi       = '0;
    lo       = '0;
    div_zero = 1'b0;

    if (op == MD_MULT) begin
      ext_a = {{32{a[31]}}, a};
      ext_b = {{32{b[31]}}, b};
    end else begin
      ext_a = {32'd0, a};
      ext_b = {32'd0, b};
    end
    prod = ext_a * ext_b;

    sgn_div = (op == MD_DIV);
    mag_a   = (sgn_div && a[31]) ? (~a + 32'd1) : a;
    mag_b   = (sgn_div && b[31]) ? (~b + 32'd1) : b;
    safe_b  = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quo     = mag_a / safe_b;
    rem     = mag_a % safe_b;
    if (sgn_div && (a[31] ^ b[31])) quo = ~quo + 32'd1;
    if (sgn_div && a[31])           rem = ~rem + 32'd1;

    case (op)
      MD_MULT, MD_MULTU: begin
        hi = prod[63:32];
        lo = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        hi       = rem;
        lo       = quo;
        div_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO. A start pulse latches the result
// into shadow registers; HI/LO are updated when the busy countdown expires.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  md_op,
  input  logic        start,
  input  logic        sel_hi,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  md_op_e      op;
  md_state_e   state;
  logic [3:0]  cnt,  cnt_nxt;
  logic        busy_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic [31:0] hi_t, lo_t, hi_t_nxt, lo_t_nxt;
  logic        wr_t, wr_t_nxt;
  logic [31:0] res_hi, res_lo;
  logic        res_div_zero;

  assign op     = md_op_e'(md_op);
  assign state  = (cnt == 4'd0) ? ST_IDLE : ST_RUN;
  assign md_out = sel_hi ? HI : LO;

  md_arith u_arith (
    .a        (A),
    .b        (B),
    .op       (op),
    .hi       (res_hi),
    .lo       (res_lo),
    .div_zero (res_div_zero)
  );

  // Next-state logic: accept a start when idle, count down when running, commit at cnt==1.
  always_comb begin
    cnt_nxt  = cnt;
    busy_nxt = busy;
    hi_nxt   = HI;
    lo_nxt   = LO;
    hi_t_nxt = hi_t;
    lo_t_nxt = lo_t;
    wr_t_nxt = wr_t;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_arith_op(op)) begin
            hi_t_nxt = res_hi;
            lo_t_nxt = res_lo;
            wr_t_nxt = !res_div_zero;
            cnt_nxt  = ((op == MD_MULT) || (op == MD_MULTU)) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            busy_nxt = 1'b1;
          end
        end else if (op == MD_MTHI) begin
          hi_nxt = A;
        end else if (op == MD_MTLO) begin
          lo_nxt = A;
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          busy_nxt = 1'b0;
          if (wr_t) begin
            hi_nxt = hi_t;
            lo_nxt = lo_t;
          end
        end
      end
      default: ;
    endcase
  end

  // State register with synchronous reset; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
      HI   <= '0;
      LO   <= '0;
      hi_t <= '0;
      lo_t <= '0;
      wr_t <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= busy_nxt;
      HI   <= hi_nxt;
      LO   <= lo_nxt;
      hi_t <= hi_t_nxt;
      lo_t <= lo_t_nxt;
      wr_t <= wr_t_nxt;
    end
  end

endmodule
